seg7_scan_decoder: RTL and testbench

Reads a time-multiplexed, active-low 7-segment bus (segment lines plus one-hot active-low digit selects) and recovers the hex nibble shown on each digit. A pattern is captured only after it has been stable for a programmable number of cycles, and each capture is offered on a valid/ready stream. The block sits opposite the hex-to-segment display path and is used for loopback self-test and for capturing external display modules. It provides the decode direction of the team's segment encoding.

---
 rtl/seg7_scan_decoder_pkg.sv | 68 ++++++
 rtl/seg7_scan_decoder_if.sv | 32 +++
 rtl/seg7_scan_decoder_decode.sv | 14 +
 rtl/seg7_scan_decoder.sv | 159 +++++++++++++++
 tb/tb_seg7_scan_decoder.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/seg7_scan_decoder_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared definitions for the 7-segment decode path: active-low segment codes
// (bit0 = a ... bit6 = g), the scan-decoder FSM state type and the code-to-nibble
// decode function that is also used by the encoder's bench.
// -----------------------------------------------------------------------------
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_A     = 7'h08;
    localparam logic [6:0] SEG_B     = 7'h03;
    localparam logic [6:0] SEG_C     = 7'h46;
    localparam logic [6:0] SEG_D     = 7'h21;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_F     = 7'h0E;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        IDLE,
        TRACK,
        HOLD
    } state_e;

    typedef struct packed {
        logic [3:0] nibble;
        logic       blank;
        logic       error;
    } seg_dec_t;

    // Nibble is forced to zero for blank and unrecognised codes.
    function automatic seg_dec_t seg7_decode_fn(input logic [6:0] code);
        seg_dec_t r;
        r.nibble = '0;
        r.blank  = 1'b0;
        r.error  = 1'b0;
        case (code)
            SEG_0:     r.nibble = 4'h0;
            SEG_1:     r.nibble = 4'h1;
            SEG_2:     r.nibble = 4'h2;
            SEG_3:     r.nibble = 4'h3;
            SEG_4:     r.nibble = 4'h4;
            SEG_5:     r.nibble = 4'h5;
            SEG_6:     r.nibble = 4'h6;
            SEG_7:     r.nibble = 4'h7;
            SEG_8:     r.nibble = 4'h8;
            SEG_9:     r.nibble = 4'h9;
            SEG_A:     r.nibble = 4'hA;
            SEG_B:     r.nibble = 4'hB;
            SEG_C:     r.nibble = 4'hC;
            SEG_D:     r.nibble = 4'hD;
            SEG_E:     r.nibble = 4'hE;
            SEG_F:     r.nibble = 4'hF;
            SEG_BLANK: r.blank  = 1'b1;
            default:   r.error  = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/seg7_scan_decoder_if.sv
// -----------------------------------------------------------------------------
// seg7_stream_if
// Valid/ready capture-event stream of the scan decoder.
//   out_valid  : capture event pending (master -> slave)
//   out_ready  : consumer accepts the event (slave -> master)
//   out_digit  : index of the captured digit
//   out_nibble : decoded value (0 on blank or error)
//   out_blank  : event is the all-off pattern
//   out_error  : event is an unrecognised pattern
// -----------------------------------------------------------------------------
interface seg7_stream_if #(
    parameter int unsigned NUM_DIGITS = 4
);
    localparam int unsigned DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_digit;
    logic [3:0]    out_nibble;
    logic          out_blank;
    logic          out_error;

    modport master (
        output out_valid, out_digit, out_nibble, out_blank, out_error,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_digit, out_nibble, out_blank, out_error,
        output out_ready
    );
endinterface

// File: rtl/seg7_scan_decoder_decode.sv
// -----------------------------------------------------------------------------
// seg7_decode
// Combinational decode of an active-low 7-segment code.
//   code_i : segment code, bit0 = a ... bit6 = g
//   dec_o  : {nibble, blank, error}
// -----------------------------------------------------------------------------
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [6:0] code_i,
    output seg_dec_t   dec_o
);
    assign dec_o = seg7_decode_fn(code_i);
endmodule

// File: rtl/seg7_scan_decoder.sv
// -----------------------------------------------------------------------------
// seg7_scan_decoder
// Recovers per-digit hex values from a time-multiplexed active-low 7-segment
// bus. A {segments, digit select} pattern is captured once it has been stable
// for STABLE_CYCLES consecutive samples; each capture is offered on out_if.
//   clk, rst   : clock, synchronous active-high reset
//   seg_in     : segment lines, active-low
//   dig_sel    : digit enables, active-low one-hot
//   out_if     : capture-event stream (master side)
//   digits     : latest nibble per digit, digit i at [4i+3:4i]
//   blank_mask : digit last captured blank (or never captured)
//   frame_done : one-cycle pulse once every digit has been captured
//   overflow   : sticky, a capture event was dropped
// -----------------------------------------------------------------------------
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS    = 4,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [6:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   dig_sel,
    seg7_stream_if.master           out_if,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]   blank_mask,
    output logic                    frame_done,
    output logic                    overflow
);
    localparam int unsigned DW       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [7:0]  STABLE_W = 8'(STABLE_CYCLES);
    localparam logic [7:0]  STABLE_M1 = 8'(STABLE_CYCLES - 1);

    // Sampler, counter, FSM
    logic [6:0]            seg_q;
    logic [NUM_DIGITS-1:0] sel_q;
    logic [7:0]            cnt_q, cnt_d;
    state_e                state_q;

    // Digit file and holding register
    logic [4*NUM_DIGITS-1:0] digits_q;
    logic [NUM_DIGITS-1:0]   bmask_q;
    logic [NUM_DIGITS-1:0]   seen_q;
    logic                    fd_q;
    logic                    ovf_q;
    logic                    valid_q;
    logic [DW-1:0]           digit_q;
    logic [3:0]              nib_q;
    logic                    blank_q;
    logic                    err_q;

    logic                  pins_onehot;
    logic                  pins_same;
    logic                  capture;
    logic [DW-1:0]         idx;
    logic [NUM_DIGITS-1:0] seen_set;
    seg_dec_t              dec;

    seg7_decode u_decode (
        .code_i (seg_q),
        .dec_o  (dec)
    );

    always_comb begin
        pins_onehot = $onehot(~dig_sel);
        pins_same   = (seg_in == seg_q) && (dig_sel == sel_q);
        cnt_d       = '0;
        if (pins_same && pins_onehot)
            cnt_d = (cnt_q == STABLE_W) ? cnt_q : cnt_q + 8'd1;
        // Capture on the edge where the count reaches STABLE_CYCLES.
        capture = (state_q == TRACK) && pins_same && pins_onehot && (cnt_q == STABLE_M1);
    end

    always_comb begin
        idx = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++)
            if (!sel_q[i]) idx = DW'(i);
        seen_set = seen_q | ~sel_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q   <= '1;
            sel_q   <= '1;
            cnt_q   <= '0;
            state_q <= IDLE;
        end else begin
            seg_q <= seg_in;
            sel_q <= dig_sel;
            cnt_q <= cnt_d;
            if (!pins_onehot) begin
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE:    state_q <= TRACK;
                    TRACK:   if (capture) state_q <= HOLD;
                    HOLD:    if (!pins_same) state_q <= TRACK;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            digits_q <= '0;
            bmask_q  <= '1;
            seen_q   <= '0;
            fd_q     <= 1'b0;
            ovf_q    <= 1'b0;
            valid_q  <= 1'b0;
            digit_q  <= '0;
            nib_q    <= '0;
            blank_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            fd_q <= 1'b0;
            if (capture) begin
                for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                    if (!sel_q[i] && !dec.error) begin
                        digits_q[4*i +: 4] <= dec.nibble;
                        bmask_q[i]         <= dec.blank;
                    end
                end
                if (&seen_set) begin
                    seen_q <= '0;
                    fd_q   <= 1'b1;
                end else begin
                    seen_q <= seen_set;
                end
                // A full, unaccepted slot drops the new event; an accepted
                // slot is refilled in the same edge so valid never dips.
                if (valid_q && !out_if.out_ready) begin
                    ovf_q <= 1'b1;
                end else begin
                    valid_q <= 1'b1;
                    digit_q <= idx;
                    nib_q   <= dec.nibble;
                    blank_q <= dec.blank;
                    err_q   <= dec.error;
                end
            end else if (valid_q && out_if.out_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign out_if.out_valid  = valid_q;
    assign out_if.out_digit  = digit_q;
    assign out_if.out_nibble = nib_q;
    assign out_if.out_blank  = blank_q;
    assign out_if.out_error  = err_q;
    assign digits            = digits_q;
    assign blank_mask        = bmask_q;
    assign frame_done        = fd_q;
    assign overflow          = ovf_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_decoder
// Self-checking bench for seg7_scan_decoder (4 digits, 4 stable cycles).
// A run-length reference model tracks expected outputs every cycle; decode
// vectors and directed corner sequences add constant expectations.
// -----------------------------------------------------------------------------
module tb_seg7_scan_decoder;
    localparam int ND = 4;
    localparam int SC = 4;

    logic       clk;
    logic       rst;
    logic [6:0] seg_in;
    logic [3:0] dig_sel;
    logic [15:0] digits;
    logic [3:0] blank_mask;
    logic       frame_done;
    logic       overflow;

    seg7_stream_if #(.NUM_DIGITS(ND)) sif ();

    seg7_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
        .clk        (clk),
        .rst        (rst),
        .seg_in     (seg_in),
        .dig_sel    (dig_sel),
        .out_if     (sif),
        .digits     (digits),
        .blank_mask (blank_mask),
        .frame_done (frame_done),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [6:0] codes [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Reference model state
    logic [6:0]  m_pseg;
    logic [3:0]  m_psel;
    int          m_run;
    bit          m_valid;
    int          m_digit;
    logic [3:0]  m_nib;
    bit          m_blank, m_err, m_ovf, m_fd;
    logic [15:0] m_digits;
    logic [3:0]  m_bmask, m_seen;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endfunction

    // Capture happens when an identical one-hot pattern has been sampled on
    // exactly SC+1 consecutive edges.
    task automatic model_edge(input logic [6:0] seg, input logic [3:0] sel,
                              input logic rdy, input logic r);
        int         idx;
        logic [3:0] nib;
        bit         blk, err;
        if (r) begin
            m_pseg = '1; m_psel = '1; m_run = 0;
            m_valid = 0; m_digit = 0; m_nib = 0; m_blank = 0; m_err = 0;
            m_ovf = 0; m_fd = 0; m_digits = '0; m_bmask = 4'hF; m_seen = '0;
        end else begin
            m_fd = 0;
            if (seg == m_pseg && sel == m_psel) begin
                if (m_run < 1000) m_run++;
            end else begin
                m_run = 1;
            end
            m_pseg = seg;
            m_psel = sel;
            if ($countones(~sel) == 1 && m_run == SC + 1) begin
                idx = 0;
                for (int i = 0; i < ND; i++) if (!sel[i]) idx = i;
                nib = 4'h0;
                blk = (seg == 7'h7F);
                err = !blk;
                for (int v = 0; v < 16; v++)
                    if (codes[v] == seg) begin nib = 4'(v); err = 0; end
                if (!err) begin
                    m_digits[4*idx +: 4] = nib;
                    m_bmask[idx] = blk;
                end
                m_seen[idx] = 1'b1;
                if (m_seen == 4'hF) begin m_fd = 1; m_seen = '0; end
                if (m_valid && !rdy) begin
                    m_ovf = 1;
                end else begin
                    m_valid = 1; m_digit = idx; m_nib = nib; m_blank = blk; m_err = err;
                end
            end else if (m_valid && rdy) begin
                m_valid = 0;
            end
        end
    endtask

    task automatic check_all();
        chk("valid", 32'(sif.out_valid), 32'(m_valid));
        if (m_valid) begin
            chk("out_digit",  32'(sif.out_digit),  32'(m_digit));
            chk("out_nibble", 32'(sif.out_nibble), 32'(m_nib));
            chk("out_blank",  32'(sif.out_blank),  32'(m_blank));
            chk("out_error",  32'(sif.out_error),  32'(m_err));
        end
        chk("digits",     32'(digits),     32'(m_digits));
        chk("blank_mask", 32'(blank_mask), 32'(m_bmask));
        chk("frame_done", 32'(frame_done), 32'(m_fd));
        chk("overflow",   32'(overflow),   32'(m_ovf));
    endtask

    task automatic step(input logic [6:0] seg, input logic [3:0] sel,
                        input logic rdy, input logic r);
        seg_in = seg; dig_sel = sel; sif.out_ready = rdy; rst = r;
        @(posedge clk);
        model_edge(seg, sel, rdy, r);
        @(negedge clk);
        check_all();
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_valid"},  32'(sif.out_valid),  32'd0);
        chk({tag, "_digit"},  32'(sif.out_digit),  32'd0);
        chk({tag, "_nibble"}, 32'(sif.out_nibble), 32'd0);
        chk({tag, "_blank"},  32'(sif.out_blank),  32'd0);
        chk({tag, "_error"},  32'(sif.out_error),  32'd0);
        chk({tag, "_digits"}, 32'(digits),         32'd0);
        chk({tag, "_bmask"},  32'(blank_mask),     32'hF);
        chk({tag, "_fd"},     32'(frame_done),     32'd0);
        chk({tag, "_ovf"},    32'(overflow),       32'd0);
    endtask

    // Hold one pattern for n edges; returns payload seen after edge SC+1.
    task automatic dwell(input logic [6:0] seg, input logic [3:0] sel, input logic rdy,
                         input int n);
        for (int k = 0; k < n; k++) step(seg, sel, rdy, 1'b0);
    endtask

    typedef struct {
        logic [6:0] code;
        logic [3:0] nib;
        logic       blank;
        logic       err;
    } vec_t;

    vec_t vecs [20];

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int first;
        int pulses;
        int vcount;
        logic [3:0] sel;

        vecs = '{
            '{7'h40, 4'h0, 1'b0, 1'b0}, '{7'h79, 4'h1, 1'b0, 1'b0},
            '{7'h24, 4'h2, 1'b0, 1'b0}, '{7'h30, 4'h3, 1'b0, 1'b0},
            '{7'h19, 4'h4, 1'b0, 1'b0}, '{7'h12, 4'h5, 1'b0, 1'b0},
            '{7'h02, 4'h6, 1'b0, 1'b0}, '{7'h78, 4'h7, 1'b0, 1'b0},
            '{7'h00, 4'h8, 1'b0, 1'b0}, '{7'h10, 4'h9, 1'b0, 1'b0},
            '{7'h08, 4'hA, 1'b0, 1'b0}, '{7'h03, 4'hB, 1'b0, 1'b0},
            '{7'h46, 4'hC, 1'b0, 1'b0}, '{7'h21, 4'hD, 1'b0, 1'b0},
            '{7'h06, 4'hE, 1'b0, 1'b0}, '{7'h0E, 4'hF, 1'b0, 1'b0},
            '{7'h7F, 4'h0, 1'b1, 1'b0}, '{7'h55, 4'h0, 1'b0, 1'b1},
            '{7'h7E, 4'h0, 1'b0, 1'b1}, '{7'h01, 4'h0, 1'b0, 1'b1}
        };

        seg_in = 7'h7F; dig_sel = 4'hF; sif.out_ready = 1'b0; rst = 1'b1;
        @(negedge clk);
        step(7'h7F, 4'hF, 1'b0, 1'b1);
        step(7'h7F, 4'hF, 1'b0, 1'b1);
        check_reset_vals("reset");

        // Steady '2' on digit 0: capture after edge 5, then no second event.
        first = -1;
        for (int e = 1; e <= 12; e++) begin
            step(7'h24, 4'b1110, 1'b1, 1'b0);
            if (sif.out_valid && first < 0) first = e;
        end
        chk("steady_first_edge", 32'(first), 32'd5);
        chk("steady_digits0", 32'(digits[3:0]), 32'h2);
        chk("steady_bmask0", 32'(blank_mask[0]), 32'd0);

        // One-cycle glitch to 8 at edge 3 restarts the count.
        step(7'h7F, 4'hF, 1'b1, 1'b0);
        first = -1;
        vcount = 0;
        for (int e = 1; e <= 12; e++) begin
            step((e == 3) ? 7'h00 : 7'h24, 4'b1110, 1'b1, 1'b0);
            if (sif.out_valid) begin
                vcount++;
                if (first < 0) begin
                    first = e;
                    chk("glitch_nibble", 32'(sif.out_nibble), 32'h2);
                end
            end
        end
        chk("glitch_first_edge", 32'(first), 32'd8);
        chk("glitch_event_count", 32'(vcount), 32'd1);

        // Decode vectors, alternating digits so each dwell is a new pattern.
        for (int k = 0; k < 20; k++) begin
            sel = ~(4'b0001 << (k % 4));
            dwell(vecs[k].code, sel, 1'b1, SC + 1);
            chk("vec_valid",  32'(sif.out_valid),  32'd1);
            chk("vec_digit",  32'(sif.out_digit),  32'(k % 4));
            chk("vec_nibble", 32'(sif.out_nibble), 32'(vecs[k].nib));
            chk("vec_blank",  32'(sif.out_blank),  32'(vecs[k].blank));
            chk("vec_error",  32'(sif.out_error),  32'(vecs[k].err));
            step(vecs[k].code, sel, 1'b1, 1'b0);
        end

        // Scan 0..3 across digits 0..3.
        step(7'h7F, 4'hF, 1'b1, 1'b1);
        pulses = 0;
        for (int d = 0; d < 4; d++)
            for (int k = 0; k < 6; k++) begin
                step(codes[d], ~(4'b0001 << d), 1'b1, 1'b0);
                if (frame_done) pulses++;
            end
        chk("scan_digits", 32'(digits), 32'h3210);
        chk("scan_bmask", 32'(blank_mask), 32'h0);
        chk("scan_frame_pulses", 32'(pulses), 32'd1);

        // Back-pressure: first event held, later ones dropped.
        dwell(7'h79, 4'b1110, 1'b0, 6);
        dwell(7'h30, 4'b1101, 1'b0, 6);
        dwell(7'h7F, 4'b1011, 1'b0, 6);
        chk("ovf_valid", 32'(sif.out_valid), 32'd1);
        chk("ovf_digit", 32'(sif.out_digit), 32'd0);
        chk("ovf_nibble", 32'(sif.out_nibble), 32'h1);
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_digits", 32'(digits), 32'h3031);
        chk("ovf_bmask", 32'(blank_mask), 32'b0100);
        step(7'h7F, 4'b1011, 1'b1, 1'b0);
        chk("ovf_drain", 32'(sif.out_valid), 32'd0);
        dwell(7'h7F, 4'b0111, 1'b1, SC + 1);
        chk("blank_valid", 32'(sif.out_valid), 32'd1);
        chk("blank_flag", 32'(sif.out_blank), 32'd1);
        chk("blank_nibble", 32'(sif.out_nibble), 32'd0);
        chk("blank_digit", 32'(sif.out_digit), 32'd3);
        chk("blank_bmask", 32'(blank_mask), 32'b1100);
        step(7'h7F, 4'b0111, 1'b1, 1'b0);

        // Unrecognised pattern on digit 1 leaves the digit file alone.
        dwell(7'h55, 4'b1101, 1'b1, SC + 1);
        chk("err_flag", 32'(sif.out_error), 32'd1);
        chk("err_nibble", 32'(sif.out_nibble), 32'd0);
        chk("err_digit1", 32'(digits[7:4]), 32'h3);
        step(7'h55, 4'b1101, 1'b1, 1'b0);

        // Reset in the middle of a count.
        dwell(7'h24, 4'b1110, 1'b0, 3);
        step(7'h24, 4'b1110, 1'b0, 1'b1);
        check_reset_vals("midrst");

        // Two digits active: never captured.
        vcount = 0;
        for (int k = 0; k < 12; k++) begin
            step(7'h24, 4'b1100, 1'b1, 1'b0);
            if (sif.out_valid) vcount++;
        end
        chk("twohot_events", 32'(vcount), 32'd0);
        chk("twohot_digits", 32'(digits), 32'd0);

        // Randomised traffic against the reference model.
        for (int blk = 0; blk < 300; blk++) begin
            logic [6:0] s;
            logic [3:0] d;
            int len;
            len = $urandom_range(1, 9);
            if ($urandom_range(0, 9) < 9) d = ~(4'b0001 << $urandom_range(0, 3));
            else d = 4'($urandom);
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: s = codes[$urandom_range(0, 15)];
                6:                s = 7'h7F;
                default:          s = 7'($urandom);
            endcase
            for (int k = 0; k < len; k++)
                step(s, d, ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
                     ($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
